// File: rtl/goe_nport.sv
// ---------------------------------------------------------------------------
// goe_nport -- egress demux at the tail of the UM pipeline.
//
// Routes each packet to one of NPORT output channels. A packet is framed by
// the flag in data[DW-1:DW-2]: head 01, mid 11, tail 10. The head word
// carries the destination in its 6-bit outport field
// (data[OP_LSB+5:OP_LSB]). If that field is >= NPORT, the whole packet is
// dropped. Every output is registered, so a word appears on its port exactly
// one clock after it is accepted. There is no backpressure.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_data_wr      input word strobe
//   in_data         input word [DW]
//   in_valid_wr     packet-valid strobe (accompanies tail word)
//   in_valid        packet-valid flag
//   cnt_clr         synchronous clear of all statistics counters
//   out_data_wr     per-port word strobe [NPORT]
//   out_data        per-port word, port p at [p*DW +: DW]
//   out_valid_wr    per-port packet-valid strobe [NPORT]
//   out_valid       per-port packet-valid flag [NPORT]
//   tx_pkt_cnt      tails forwarded per port, port p at [p*CW +: CW]
//   drop_cnt        packets dropped for outport >= NPORT
//   err_cnt         framing errors (stray words, head while in packet)
// ---------------------------------------------------------------------------
module goe_nport #(
  parameter int NPORT  = 4,
  parameter int DW     = 134,
  parameter int OP_LSB = 112,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_data_wr,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid_wr,
  input  logic                in_valid,
  input  logic                cnt_clr,
  output logic [NPORT-1:0]    out_data_wr,
  output logic [NPORT*DW-1:0] out_data,
  output logic [NPORT-1:0]    out_valid_wr,
  output logic [NPORT-1:0]    out_valid,
  output logic [NPORT*CW-1:0] tx_pkt_cnt,
  output logic [CW-1:0]       drop_cnt,
  output logic [CW-1:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [5:0] NPORT_OP = 6'(NPORT);

  state_t        state, nxt_state;
  logic [5:0]    sel_port, nxt_sel;
  logic [CW-1:0] tx_cnt [NPORT];

  // Decode of the incoming word.
  logic [1:0] flag;
  logic [5:0] op;
  logic       is_head, is_tail, op_ok;

  assign flag    = in_data[DW-1:DW-2];
  assign op      = in_data[OP_LSB +: 6];
  assign is_head = (flag == 2'b01);
  assign is_tail = (flag == 2'b10);
  assign op_ok   = (op < NPORT_OP);

  // Routing decisions for this cycle.
  logic             fwd;       // word goes out on fwd_port
  logic             vfwd;      // valid strobe/flag goes out on fwd_port
  logic [5:0]       fwd_port;
  logic             inc_tx, inc_drop, inc_err;
  logic [NPORT-1:0] port_hit, vport_hit;

  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves one unassigned (no latches).
    nxt_state = state;
    nxt_sel   = sel_port;
    fwd       = 1'b0;
    fwd_port  = sel_port;
    inc_tx    = 1'b0;
    inc_drop  = 1'b0;
    inc_err   = 1'b0;

    if (in_data_wr) begin
      if (is_head) begin
        // A head outside IDLE truncates (FWD) or interrupts (DROP) the prior
        // packet. It is an error, and the head is routed afresh.
        inc_err = (state != IDLE);
        if (op_ok) begin
          fwd       = 1'b1;
          fwd_port  = op;
          nxt_sel   = op;
          nxt_state = FWD;
        end else begin
          inc_drop  = 1'b1;
          nxt_state = DROP;
        end
      end else begin
        unique case (state)
          IDLE: inc_err = 1'b1;
          FWD: begin
            fwd = 1'b1;
            if (is_tail) begin
              inc_tx    = 1'b1;
              nxt_state = IDLE;
            end
          end
          DROP: if (is_tail) nxt_state = IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end

    // Valid follows the forwarded word. On idle cycles it follows an open packet.
    vfwd = in_data_wr ? fwd : (state == FWD);

    for (int p = 0; p < NPORT; p++) begin
      port_hit[p]  = fwd  && (fwd_port == 6'(p));
      vport_hit[p] = vfwd && (fwd_port == 6'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel_port     <= '0;
      out_data_wr  <= '0;
      out_data     <= '0;
      out_valid_wr <= '0;
      out_valid    <= '0;
      drop_cnt     <= '0;
      err_cnt      <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset with everything else.
      for (int p = 0; p < NPORT; p++) tx_cnt[p] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
      state    <= nxt_state;
      sel_port <= nxt_sel;

      for (int p = 0; p < NPORT; p++) begin
        out_data_wr[p]        <= port_hit[p];
        out_data[p*DW +: DW]  <= port_hit[p] ? in_data : '0;
        out_valid_wr[p]       <= vport_hit[p] & in_valid_wr;
        out_valid[p]          <= vport_hit[p] & in_valid;
      end

      // Clear wins over a same-cycle increment. Counters wrap naturally.
      if (cnt_clr) begin
        drop_cnt <= '0;
        err_cnt  <= '0;
        for (int p = 0; p < NPORT; p++) tx_cnt[p] <= '0;
      end else begin
        if (inc_drop) drop_cnt <= drop_cnt + 1'b1;
        if (inc_err)  err_cnt  <= err_cnt + 1'b1;
        for (int p = 0; p < NPORT; p++)
          if (inc_tx && (sel_port == 6'(p))) tx_cnt[p] <= tx_cnt[p] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_cnt
    assign tx_pkt_cnt[g*CW +: CW] = tx_cnt[g];
  end

endmodule

// File: tb/tb_goe_nport.sv
// ---------------------------------------------------------------------------
// tb_goe_nport -- scoreboard bench for goe_nport.
// Directed packets are driven with the port they must appear on. A monitor
// pops the scoreboard whenever the DUT raises an output strobe. Counter
// values are checked against hand-computed constants. Counters are 8 bits
// wide here so the wrap point is reachable in a few hundred packets.
// ---------------------------------------------------------------------------
module tb_goe_nport;

  localparam int NPORT  = 4;
  localparam int DW     = 134;
  localparam int OP_LSB = 112;
  localparam int CW     = 8;
  localparam int VW     = NPORT*DW;

  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] T = 2'b10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_data_wr, in_valid_wr, in_valid, cnt_clr;
  logic [DW-1:0]       in_data;
  logic [NPORT-1:0]    out_data_wr, out_valid_wr, out_valid;
  logic [NPORT*DW-1:0] out_data;
  logic [NPORT*CW-1:0] tx_pkt_cnt;
  logic [CW-1:0]       drop_cnt, err_cnt;

  goe_nport #(.NPORT(NPORT), .DW(DW), .OP_LSB(OP_LSB), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data_wr   (in_data_wr),
    .in_data      (in_data),
    .in_valid_wr  (in_valid_wr),
    .in_valid     (in_valid),
    .cnt_clr      (cnt_clr),
    .out_data_wr  (out_data_wr),
    .out_data     (out_data),
    .out_valid_wr (out_valid_wr),
    .out_valid    (out_valid),
    .tx_pkt_cnt   (tx_pkt_cnt),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          vwr;
    logic          v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] f, input logic [5:0] op, input logic [31:0] pay);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1:DW-2]   = f;
    w[OP_LSB +: 6] = op;
    w[31:0]        = pay;
    return w;
  endfunction

  function automatic logic [CW-1:0] tx(input int p);
    return tx_pkt_cnt[p*CW +: CW];
  endfunction

  // exp_port < 0 means the word must not appear on any port.
  task automatic word(input logic [1:0] f, input int op, input logic [31:0] pay,
                      input int exp_port, input bit vwr = 1'b0, input bit clr = 1'b0);
    @(negedge clk);
    in_data     = mk(f, 6'(op), pay);
    in_data_wr  = 1'b1;
    in_valid_wr = vwr;
    in_valid    = vwr;
    cnt_clr     = clr;
    if (exp_port >= 0) sb.push_back('{exp_port, in_data, vwr, vwr});
  endtask

  task automatic idle();
    @(negedge clk);
    in_data     = '0;
    in_data_wr  = 1'b0;
    in_valid_wr = 1'b0;
    in_valid    = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  // Monitor: every cycle with an output strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ((|out_data_wr) || (|out_valid_wr))) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: dwr=%b vwr=%b, expected no strobe", out_data_wr, out_valid_wr);
      end else begin
        exp_t          e;
        logic [VW-1:0] exp_data;
        e = sb.pop_front();
        exp_data = '0;
        exp_data[e.port*DW +: DW] = e.data;
        check("port_strobe", VW'(out_data_wr),  VW'(NPORT'(1) << e.port));
        check("port_data",   out_data,          exp_data);
        check("valid_wr",    VW'(out_valid_wr), VW'(NPORT'(e.vwr) << e.port));
        check("valid",       VW'(out_valid),    VW'(NPORT'(e.v) << e.port));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_data_wr = 1'b0;
    in_valid_wr = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dwr",  VW'(out_data_wr), '0);
    check("rst_data", out_data, '0);
    check("rst_cnt",  VW'({tx_pkt_cnt, drop_cnt, err_cnt}), '0);
    rst_n = 1'b1;

    // 1: 3-word packet to port 2, valid on tail
    word(H, 2, 32'h101, 2);
    word(M, 0, 32'h102, 2);
    word(T, 0, 32'h103, 2, 1'b1);
    idle();
    check("t1_tx2", VW'(tx(2)), VW'(8'd1));

    // 2: outport 5 dropped whole, then a normal packet to port 0
    word(H, 5, 32'h201, -1);
    word(M, 0, 32'h202, -1);
    word(M, 0, 32'h203, -1);
    word(T, 0, 32'h204, -1, 1'b1);
    idle();
    check("t2_drop", VW'(drop_cnt), VW'(8'd1));
    check("t2_err",  VW'(err_cnt),  VW'(8'd0));
    word(H, 0, 32'h211, 0);
    word(T, 0, 32'h212, 0, 1'b1);
    idle();
    check("t2_tx0", VW'(tx(0)), VW'(8'd1));

    // 3: packet to port 1 truncated by a new head to port 3
    word(H, 1, 32'h301, 1);
    word(M, 0, 32'h302, 1);
    word(H, 3, 32'h303, 3);
    word(M, 0, 32'h304, 3);
    word(T, 0, 32'h305, 3, 1'b1);
    idle();
    check("t3_err", VW'(err_cnt), VW'(8'd1));
    check("t3_tx1", VW'(tx(1)),   VW'(8'd0));
    check("t3_tx3", VW'(tx(3)),   VW'(8'd1));

    // 4: stray mid and tail in IDLE, then a packet with idle gaps
    word(M, 0, 32'h401, -1);
    word(T, 0, 32'h402, -1);
    idle();
    check("t4_err", VW'(err_cnt), VW'(8'd3));
    word(H, 2, 32'h411, 2);
    idle();
    word(M, 0, 32'h412, 2);
    idle();
    idle();
    word(T, 0, 32'h413, 2, 1'b1);
    idle();
    check("t4_tx2",     VW'(tx(2)),   VW'(8'd2));
    check("t4_err_gap", VW'(err_cnt), VW'(8'd3));

    // 5: wrap tx_pkt_cnt[0] (currently 1) through all-ones, then clear beats increment
    for (int i = 0; i < 254; i++) begin
      word(H, 0, 32'h5000 + i, 0);
      word(T, 0, 32'h6000 + i, 0);
    end
    idle();
    check("t5_full", VW'(tx(0)), VW'(8'hFF));
    word(H, 0, 32'h501, 0);
    word(T, 0, 32'h502, 0);
    idle();
    check("t5_wrap", VW'(tx(0)), VW'(8'h00));
    word(H, 0, 32'h503, 0);
    word(T, 0, 32'h504, 0);
    word(H, 0, 32'h505, 0);
    word(T, 0, 32'h506, 0, 1'b0, 1'b1);
    idle();
    check("t5_clr_tx", VW'(tx_pkt_cnt), '0);
    check("t5_clr_de", VW'({drop_cnt, err_cnt}), '0);

    // 6: reset in the middle of a packet to port 1
    word(H, 1, 32'h601, 1);
    word(M, 0, 32'h602, 1);
    @(negedge clk);
    in_data_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_dwr",  VW'(out_data_wr), '0);
    check("t6_rst_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    word(M, 0, 32'h603, -1);
    word(T, 0, 32'h604, -1, 1'b1);
    idle();
    check("t6_err", VW'(err_cnt),    VW'(8'd2));
    check("t6_tx",  VW'(tx_pkt_cnt), '0);
    word(H, 3, 32'h611, 3);
    word(T, 0, 32'h612, 3, 1'b1);
    idle();
    check("t6_tx3", VW'(tx(3)), VW'(8'd1));

    repeat (3) idle();
    check("sb_empty", VW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
